clock_sequencer: RTL and testbench
==================================

Name: clock_sequencer

Overview:
- Controller for the two-phase CPU clock.
- Derives non-overlapping ph0/ph1 phase levels from clkin and adds run/halt control, single-step, memory wait-state stretching and CPU reset sequencing.
- Sits between the board clock and the core; a debugger or front panel drives run/step, and the memory interface drives wait_req.

Parameters:
- DIVIDE, 0, each quarter lasts L = 2^DIVIDE clkin cycles.
- RESET_CYCLES, 4, number of complete machine cycles cpu_rst stays high after rst is released and clocking starts (range 1..255).

Ports:
- clkin  in  1  system clock; all logic is on posedge clkin.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = free-running machine cycles.
- step  in  1  pulse; requests exactly one machine cycle while halted.
- wait_req  in  1  memory not ready; stretches the ph1 phase.
- ph0  out  1  phase-0 clock level.
- ph1  out  1  phase-1 clock level.
- cycle_start  out  1  one-clkin strobe on the first cycle of every ph0 high.
- halted  out  1  1 while no machine cycle is in progress.
- cpu_rst  out  1  reset to the core.
- cycle_count  out  16  completed machine cycles.

Behaviour:
- Reset (rst sampled high) gives these values on the next edge, regardless of the current state:
  - state = HALT, quarter counter = 0, step_pending = 0, reset counter = RESET_CYCLES.
  - ph0 = 0, ph1 = 0, cycle_start = 0, halted = 1, cpu_rst = 1, cycle_count = 0.
  - A mid-phase reset truncates the phase immediately.
- States: HALT, P0, G0, P1, G1.
  - ph0 = 1 exactly in P0; ph1 = 1 exactly in P1; both are 0 in G0, G1 and HALT.
  - All outputs are registered and glitch-free.
  - ph0 and ph1 are never both 1, and at least L clkin cycles of both-low separate them.
- Quarter counter: DIVIDE+1 bits, counts 0..L-1 in P0/G0/P1/G1 and resets to 0 on every state change. "Last cycle" means counter = L-1.
- HALT:
  - If run = 1 or step_pending = 1, go to P0 on the next edge and clear step_pending.
  - ph0 rises in the clkin cycle after run/step is sampled.
- Transitions on the last cycle of each phase:
  - P0 → G0.
  - G0 → P1.
  - P1 → G1 if wait_req = 0. If wait_req = 1, stay in P1 for another L cycles (counter restarts). wait_req is sampled only on the last cycle of each P1 quarter; at all other times it is ignored.
  - G1 → end of machine cycle:
    - cycle_count increments by 1 (mod 2^16, 0xFFFF wraps to 0x0000).
    - If the reset counter is > 0, decrement it; when it reaches 0, cpu_rst goes low on that same edge.
    - Next state is P0 if run = 1 or step_pending = 1 (clear step_pending), else HALT.
- Machine cycle length: 4L clkin cycles with no waits; each wait quarter adds L.
- step:
  - Any cycle with step = 1 sets step_pending (single bit). Multiple pulses before consumption collapse to one.
  - A pulse received during a machine cycle while run = 0 yields exactly one extra cycle.
  - With run = 1, the pending step is consumed by the next P0 entry and has no visible extra effect.
- run deasserted mid-cycle: the current machine cycle always completes; phases are never truncated by run.
- halted = 1 iff state = HALT.
- cycle_start = 1 only on the first clkin cycle of P0, including wait-free back-to-back cycles.
- cpu_rst:
  - Stays 1 while halted before RESET_CYCLES cycles have completed; it needs clocks to release.
  - After release it stays 0 until the next rst.

Test Plan:
- DIVIDE=0, RESET_CYCLES=4, rst for 2 cycles, then run=1:
  - ph0 = 1,0,0,0 repeating and ph1 = 0,0,1,0 repeating, starting the cycle after run is sampled.
  - cycle_start pulses every 4 cycles.
  - cpu_rst falls at the end of the 4th machine cycle (16 clkin cycles after the first ph0).
  - cycle_count = 4 at that point.
- DIVIDE=1, run=1: ph0 high 2 cycles, period 8; ph1 high 2 cycles starting 4 cycles after ph0 rises; never overlapping (assertion over 1000 cycles).
- DIVIDE=0, wait_req held high for 3 P1 samples, then low: ph1 high 4 consecutive cycles; that machine cycle is 7 cycles; cycle_count +1.
- Single-step:
  - run=0, halted=1, one step pulse → exactly one ph0 and one ph1 pulse, halted back to 1, cycle_count +1.
  - Three step pulses during one active cycle → exactly one further cycle.
- run dropped on the first P0 cycle → G0, P1, G1 complete normally; halted=1 on the following cycle; no second cycle_start.
- rst asserted on the 2nd cycle of P1 (DIVIDE=1), plus cycle_count preloaded to 0xFFFF:
  - Reset: next edge ph1=0, cpu_rst=1, cycle_count=0, halted=1.
  - Wrap (separate run from 0xFFFF): the next G1 end gives cycle_count=0x0000.

Source files
------------

// File: rtl/clock_sequencer.sv
// Two-phase non-overlapping CPU clock controller: run/halt, single-step,
// ph1 wait-state stretching and CPU reset sequencing over machine cycles.
module clock_sequencer #(
  parameter int DIVIDE       = 0,
  parameter int RESET_CYCLES = 4
) (
  input  logic        clkin,
  input  logic        rst,
  input  logic        run,
  input  logic        step,
  input  logic        wait_req,
  output logic        ph0,
  output logic        ph1,
  output logic        cycle_start,
  output logic        halted,
  output logic        cpu_rst,
  output logic [15:0] cycle_count
);

  // All-ones of DIVIDE+1 bits shifted right gives L-1.
  localparam logic [DIVIDE:0] LAST = {(DIVIDE+1){1'b1}} >> 1;

  typedef enum logic [2:0] {HALT, P0, G0, P1, G1} state_t;

  state_t          state, nxt;
  logic [DIVIDE:0] qcnt;
  logic            step_pending;
  logic [7:0]      rcnt;
  logic            last, go, cyc_end, consume;

  always_comb begin
    last    = (qcnt == LAST);
    go      = run | step_pending;
    cyc_end = (state == G1) && last;
    nxt     = state;
    unique case (state)
      HALT:    if (go) nxt = P0;
      P0:      if (last) nxt = G0;
      G0:      if (last) nxt = P1;
      P1:      if (last && !wait_req) nxt = G1;
      G1:      if (last) nxt = go ? P0 : HALT;
      default: nxt = HALT;
    endcase
    consume = ((state == HALT) || cyc_end) && go;
  end

  // Outputs are decoded from the next state so they change on the same edge as state.
  always_ff @(posedge clkin) begin
    if (rst) begin
      state        <= HALT;
      qcnt         <= '0;
      step_pending <= 1'b0;
      rcnt         <= 8'(RESET_CYCLES);
      ph0          <= 1'b0;
      ph1          <= 1'b0;
      cycle_start  <= 1'b0;
      halted       <= 1'b1;
      cpu_rst      <= 1'b1;
      cycle_count  <= 16'h0000;
    end else begin
      state        <= nxt;
      qcnt         <= (state == HALT || nxt != state || last) ? '0 : qcnt + 1'b1;
      step_pending <= step | (step_pending & ~consume);
      ph0          <= (nxt == P0);
      ph1          <= (nxt == P1);
      halted       <= (nxt == HALT);
      cycle_start  <= (nxt == P0) && (state != P0);
      if (cyc_end) begin
        cycle_count <= cycle_count + 16'd1;
        if (rcnt != 8'd0) begin
          rcnt <= rcnt - 8'd1;
          if (rcnt == 8'd1) cpu_rst <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_sequencer.sv
// Bench for clock_sequencer: DIVIDE=0 and DIVIDE=1 instances on shared inputs,
// directed scenarios plus random stimulus against a machine-cycle position model.
module tb_clock_sequencer;
  localparam int RC = 4;

  logic clkin = 1'b0;
  logic rst = 1'b1, run = 1'b0, step = 1'b0, wait_req = 1'b0;
  logic [1:0] ph0, ph1, cs, hlt, crst;
  logic [15:0] cnt [2];

  int checks = 0, failures = 0;

  // Model: position (clkin cycles) inside the current machine cycle and
  // the current length of the ph1 window.
  bit          m_act [2];
  bit          m_pend[2];
  bit          m_crst[2];
  int          m_pos [2];
  int          m_p1  [2];
  int          m_rc  [2];
  logic [15:0] m_cnt [2];

  always #5 clkin = ~clkin;

  clock_sequencer #(.DIVIDE(0), .RESET_CYCLES(RC)) u0 (
    .clkin(clkin), .rst(rst), .run(run), .step(step), .wait_req(wait_req),
    .ph0(ph0[0]), .ph1(ph1[0]), .cycle_start(cs[0]), .halted(hlt[0]),
    .cpu_rst(crst[0]), .cycle_count(cnt[0]));

  clock_sequencer #(.DIVIDE(1), .RESET_CYCLES(RC)) u1 (
    .clkin(clkin), .rst(rst), .run(run), .step(step), .wait_req(wait_req),
    .ph0(ph0[1]), .ph1(ph1[1]), .cycle_start(cs[1]), .halted(hlt[1]),
    .cpu_rst(crst[1]), .cycle_count(cnt[1]));

  task automatic model_upd(input int k);
    int L;
    L = 1 << k;
    if (rst) begin
      m_act[k] = 0; m_pend[k] = 0; m_rc[k] = RC; m_cnt[k] = 16'h0000;
      m_crst[k] = 1; m_pos[k] = 0; m_p1[k] = L;
    end else if (!m_act[k]) begin
      if (run || m_pend[k]) begin
        m_act[k] = 1; m_pos[k] = 0; m_p1[k] = L; m_pend[k] = step;
      end else m_pend[k] = m_pend[k] | step;
    end else begin
      if (m_pos[k] == 2*L + m_p1[k] - 1 && wait_req) m_p1[k] += L;
      if (m_pos[k] == 3*L + m_p1[k] - 1) begin
        m_cnt[k] = m_cnt[k] + 16'd1;
        if (m_rc[k] > 0) begin
          m_rc[k]--;
          if (m_rc[k] == 0) m_crst[k] = 0;
        end
        if (run || m_pend[k]) begin
          m_pos[k] = 0; m_p1[k] = L; m_pend[k] = step;
        end else begin
          m_act[k] = 0; m_pend[k] = m_pend[k] | step;
        end
      end else begin
        m_pos[k]++;
        m_pend[k] = m_pend[k] | step;
      end
    end
  endtask

  function automatic logic [20:0] expv(input int k);
    int L;
    logic e0, e1, ec;
    L  = 1 << k;
    e0 = m_act[k] && m_pos[k] < L;
    e1 = m_act[k] && m_pos[k] >= 2*L && m_pos[k] < 2*L + m_p1[k];
    ec = m_act[k] && m_pos[k] == 0;
    return {e0, e1, ec, !m_act[k], m_crst[k], m_cnt[k]};
  endfunction

  function automatic logic [20:0] obsv(input int k);
    return {ph0[k], ph1[k], cs[k], hlt[k], crst[k], cnt[k]};
  endfunction

  task automatic tick();
    model_upd(0);
    model_upd(1);
    @(posedge clkin);
    @(negedge clkin);
  endtask

  task automatic wait_halted();
    int n;
    n = 0;
    while (!(hlt[0] && hlt[1]) && n < 60) begin tick(); n++; end
    checks++;
    if (!(hlt[0] && hlt[1])) begin
      failures++;
      $display("FAIL halt_timeout: halted=%b required=11", hlt);
    end
  endtask

  task automatic test_reset();
    rst = 1; run = 0; step = 0; wait_req = 0;
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obsv(k) !== {5'b00011, 16'h0000}) begin
        failures++;
        $display("FAIL reset_state[%0d]: got %h required %h", k, obsv(k), {5'b00011, 16'h0000});
      end
    end
    rst = 0;
    tick();
    checks++;
    if (hlt !== 2'b11 || ph0 !== 2'b00) begin
      failures++;
      $display("FAIL reset_idle: halted=%b ph0=%b required 11/00", hlt, ph0);
    end
  endtask

  task automatic test_run();
    run = 1;
    tick();
    for (int j = 0; j <= 16; j++) begin
      checks++;
      if (ph0[0] !== (j % 4 == 0) || ph1[0] !== (j % 4 == 2) || cs[0] !== (j % 4 == 0)) begin
        failures++;
        $display("FAIL run_pattern j=%0d: ph0=%b ph1=%b cs=%b", j, ph0[0], ph1[0], cs[0]);
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obsv(k) !== expv(k)) begin
          failures++;
          $display("FAIL run_model[%0d] j=%0d: got %h required %h", k, j, obsv(k), expv(k));
        end
      end
      if (j == 15) begin
        checks++;
        if (crst[0] !== 1'b1 || cnt[0] !== 16'd3) begin
          failures++;
          $display("FAIL cpu_rst_early: cpu_rst=%b count=%0d required 1/3", crst[0], cnt[0]);
        end
      end
      if (j == 16) begin
        checks++;
        if (crst[0] !== 1'b0 || cnt[0] !== 16'd4) begin
          failures++;
          $display("FAIL cpu_rst_release: cpu_rst=%b count=%0d required 0/4", crst[0], cnt[0]);
        end
      end
      if (j < 16) tick();
    end
    run = 0;
    wait_halted();
  endtask

  task automatic test_wait();
    int n, n1;
    logic [15:0] c0;
    run = 1; wait_req = 1;
    n = 0;
    while (!cs[0] && n < 20) begin tick(); n++; end
    c0 = cnt[0];
    n = 0; n1 = 0;
    do begin
      tick(); n++;
      if (ph1[0]) n1++;
      if (n1 == 4) wait_req = 0;
    end while (!cs[0] && n < 20);
    checks++;
    if (n !== 7 || n1 !== 4) begin
      failures++;
      $display("FAIL wait_stretch: cycle_len=%0d ph1_len=%0d required 7/4", n, n1);
    end
    checks++;
    if (cnt[0] !== c0 + 16'd1) begin
      failures++;
      $display("FAIL wait_count: got %0d required %0d", cnt[0], c0 + 16'd1);
    end
    run = 0; wait_req = 0;
    wait_halted();
  endtask

  task automatic test_step();
    int n0, n1, s1;
    logic [15:0] c0, c1;
    c0 = cnt[0];
    step = 1; tick(); step = 0;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ph0[0]) n0++;
      if (ph1[0]) n1++;
    end
    checks++;
    if (n0 !== 1 || n1 !== 1 || hlt[0] !== 1'b1 || cnt[0] !== c0 + 16'd1) begin
      failures++;
      $display("FAIL single_step: ph0=%0d ph1=%0d halted=%b count=%0d required 1/1/1/%0d",
               n0, n1, hlt[0], cnt[0], c0 + 16'd1);
    end
    wait_halted();
    c1 = cnt[1];
    step = 1; tick(); step = 0; tick();
    s1 = cs[1] ? 1 : 0;
    for (int p = 0; p < 3; p++) begin
      step = 1; tick(); step = 0;
      if (cs[1]) s1++;
      tick();
      if (cs[1]) s1++;
    end
    for (int i = 0; i < 24; i++) begin
      tick();
      if (cs[1]) s1++;
    end
    checks++;
    if (s1 !== 2 || cnt[1] !== c1 + 16'd2 || hlt[1] !== 1'b1) begin
      failures++;
      $display("FAIL step_collapse: cycles=%0d count=%0d halted=%b required 2/%0d/1",
               s1, cnt[1], hlt[1], c1 + 16'd2);
    end
    wait_halted();
  endtask

  task automatic test_run_drop();
    int ncs;
    run = 1; tick(); run = 0;
    checks++;
    if (cs[0] !== 1'b1 || ph0[0] !== 1'b1) begin
      failures++;
      $display("FAIL drop_start: cs=%b ph0=%b required 1/1", cs[0], ph0[0]);
    end
    tick();
    checks++;
    if (ph0[0] !== 1'b0 || hlt[0] !== 1'b0) begin
      failures++;
      $display("FAIL drop_g0: ph0=%b halted=%b required 0/0", ph0[0], hlt[0]);
    end
    tick();
    checks++;
    if (ph1[0] !== 1'b1) begin
      failures++;
      $display("FAIL drop_p1: ph1=%b required 1", ph1[0]);
    end
    tick(); tick();
    checks++;
    if (hlt[0] !== 1'b1) begin
      failures++;
      $display("FAIL drop_halt: halted=%b required 1", hlt[0]);
    end
    ncs = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (cs[0]) ncs++; end
    checks++;
    if (ncs !== 0) begin
      failures++;
      $display("FAIL drop_restart: extra cycle_starts=%0d required 0", ncs);
    end
    wait_halted();
  endtask

  task automatic test_reset_mid_wrap();
    int n;
    run = 1;
    n = 0;
    while (!ph1[1] && n < 20) begin tick(); n++; end
    tick();
    checks++;
    if (ph1[1] !== 1'b1) begin
      failures++;
      $display("FAIL mid_p1_setup: ph1=%b required 1", ph1[1]);
    end
    rst = 1; tick(); run = 0;
    checks++;
    if (ph1[1] !== 1'b0 || crst[1] !== 1'b1 || cnt[1] !== 16'h0000 || hlt[1] !== 1'b1) begin
      failures++;
      $display("FAIL mid_p1_reset: ph1=%b cpu_rst=%b count=%h halted=%b required 0/1/0000/1",
               ph1[1], crst[1], cnt[1], hlt[1]);
    end
    tick(); rst = 0; tick();
    force u0.cycle_count = 16'hFFFF;
    force u1.cycle_count = 16'hFFFF;
    tick();
    release u0.cycle_count;
    release u1.cycle_count;
    m_cnt[0] = 16'hFFFF;
    m_cnt[1] = 16'hFFFF;
    run = 1; tick(); run = 0;
    wait_halted();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (cnt[k] !== 16'h0000) begin
        failures++;
        $display("FAIL count_wrap[%0d]: got %h required 0000", k, cnt[k]);
      end
    end
  endtask

  task automatic test_random();
    int bad, ovl;
    bad = 0; ovl = 0;
    for (int i = 0; i < 1000; i++) begin
      run      = ($urandom % 4) != 0;
      step     = ($urandom % 8) == 0;
      wait_req = ($urandom % 3) == 0;
      rst      = ($urandom % 97) == 0;
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obsv(k) !== expv(k)) begin
          failures++;
          bad++;
          if (bad <= 8)
            $display("FAIL random_model[%0d] i=%0d: got %h required %h", k, i, obsv(k), expv(k));
        end
      end
      checks++;
      if (ph0[1] && ph1[1]) begin
        failures++;
        ovl++;
        if (ovl <= 4) $display("FAIL overlap i=%0d: ph0=1 ph1=1 required not both", i);
      end
    end
    rst = 0; run = 0; step = 0; wait_req = 0;
    wait_halted();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 0; m_pend[k] = 0; m_crst[k] = 1; m_pos[k] = 0;
      m_p1[k] = 1 << k; m_rc[k] = RC; m_cnt[k] = 16'h0000;
    end
    @(negedge clkin);
    test_reset();
    test_run();
    test_wait();
    test_step();
    test_run_drop();
    test_reset_mid_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
